press_count_seg7: RTL and testbench
===================================

// Module: press_count_seg7
// PURPOSE
//  Downstream consumer of the button debouncer. Detects press edges on the debounced
//  level, keeps a wrapping 8-bit press count, and drives the two Go Board 7-segment
//  digits (hex, active-low). Sits between the debouncer output and the display pins.
// PARAMETERS
//  c_MAX_COUNT      8'hFF       last count value before wrap to 0 (1..255)
//  c_REPEAT_DELAY   12_500_000  hold cycles before auto-repeat starts (0.5 s @ 25 MHz)
//  c_REPEAT_PERIOD  2_500_000   cycles between auto-repeat increments (100 ms)
// PORTS
//  i_Clk          in   1  system clock, 25 MHz
//  i_Rst_L        in   1  asynchronous reset, active-low
//  i_Button       in   1  debounced button level, 1 = pressed
//  i_Clear        in   1  synchronous clear of count, active-high
//  o_Count        out  8  current press count
//  o_Wrap         out  1  one-cycle pulse when count wraps c_MAX_COUNT -> 0
//  o_Seg_Hi       out  7  upper hex digit, active-low, [6]=A .. [0]=G
//  o_Seg_Lo       out  7  lower hex digit, active-low, [6]=A .. [0]=G
// BEHAVIOUR
//  - Reset (i_Rst_L=0, async): o_Count=0, o_Wrap=0, o_Seg_Hi=o_Seg_Lo=7'b0000001 ("0"),
//    previous-level register r_Prev=1, hold counter=0.
//  - r_Prev=1 at reset: a button held through reset release yields no increment.
//  - Press event: i_Button=1 and r_Prev=0 at a rising edge; r_Prev <= i_Button every cycle.
//  - Increment: o_Count updates at the same edge the press is sampled (latency 1 clk from
//    i_Button rising). Release edges never count.
//  - Wrap: increment at o_Count==c_MAX_COUNT loads 0 and sets o_Wrap=1 for exactly one
//    cycle; o_Wrap=0 on all other cycles.
//  - Clear: i_Clear=1 loads o_Count=0 next edge; clear has priority over a simultaneous
//    press/repeat increment; no o_Wrap pulse on clear.
//  - Display: registered hex decode of o_Count; segments lag o_Count by 1 clk.
//    Patterns (active-low ABCDEFG): 0=0000001 1=1001111 2=0010010 3=0000110
//    4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000
//    b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
//  - o_Count width fixed at 8; c_MAX_COUNT > 255 is illegal.
// CONFIGURATION
//  - `PRESS_AUTO_REPEAT_EN defined: 24-bit hold counter runs while i_Button=1, zeroed when
//    i_Button=0 or on press edge. States IDLE -> DELAY (on press) -> REPEAT (hold counter
//    reaches c_REPEAT_DELAY-1: one increment, counter zeroed) -> REPEAT emits one increment
//    every c_REPEAT_PERIOD cycles; any i_Button=0 -> IDLE. Repeat increments follow the
//    same wrap/clear rules. Reset -> IDLE.
//  - Not defined: no hold counter/FSM; exactly one increment per press edge; c_REPEAT_*
//    unused.
// TESTING
//  1. Reset asserted mid-count (o_Count=5) -> o_Count=0, o_Wrap=0, both segs 7'b0000001
//     immediately, without a clock edge.
//  2. Single 0->1 on i_Button, held 10 clk -> o_Count 0->1 once; o_Seg_Lo=1001111 one clk
//     later; release adds nothing.
//  3. c_MAX_COUNT=8'h0F, 16 presses from 0 -> o_Count 0x0F then 0x00, o_Wrap high exactly 1
//     clk on the 16th press.
//  4. i_Clear and press edge same cycle, count=0x2A -> o_Count=0x00, no o_Wrap.
//  5. i_Button=1 across reset deassert -> o_Count stays 0 until a release then press.
//  6. `PRESS_AUTO_REPEAT_EN, c_REPEAT_DELAY=8, c_REPEAT_PERIOD=4, hold 20 clk -> increments
//     at press, +8, +12, +16, +20 (count=5); without macro -> count=1.

Source files
------------

// File: rtl/press_count_seg7.sv
// Button press counter with wrap pulse and registered two-digit hex 7-segment decode.
// Optional hold-to-repeat behaviour is enabled by defining PRESS_AUTO_REPEAT_EN.
`timescale 1ns/1ps
module press_count_seg7 #(
  parameter logic [7:0]  c_MAX_COUNT     = 8'hFF,
  parameter int unsigned c_REPEAT_DELAY  = 12_500_000,
  parameter int unsigned c_REPEAT_PERIOD = 2_500_000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Button,
  input  logic       i_Clear,
  output logic [7:0] o_Count,
  output logic       o_Wrap,
  output logic [6:0] o_Seg_Hi,
  output logic [6:0] o_Seg_Lo
);

  // An out-of-range configuration freezes the counter rather than misbehaving silently.
  localparam bit cfg_ok = (c_MAX_COUNT != 8'd0) &&
                          (c_REPEAT_DELAY >= 1) && (c_REPEAT_DELAY <= 32'h0100_0000) &&
                          (c_REPEAT_PERIOD >= 1) && (c_REPEAT_PERIOD <= 32'h0100_0000);

  logic       prev_reg;
  logic [7:0] count_reg;
  logic       wrap_reg;
  logic [6:0] seg_hi_reg;
  logic [6:0] seg_lo_reg;
  logic       press_edge;
  logic       repeat_fire;
  logic       inc;

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  assign press_edge = i_Button & ~prev_reg;

`ifdef PRESS_AUTO_REPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  localparam logic [23:0] delay_last  = 24'(c_REPEAT_DELAY - 1);
  localparam logic [23:0] period_last = 24'(c_REPEAT_PERIOD - 1);

  state_t      state_reg;
  logic [23:0] hold_reg;

  always_comb begin
    repeat_fire = 1'b0;
    if (i_Button) begin
      case (state_reg)
        DELAY:   repeat_fire = (hold_reg == delay_last);
        REPEAT:  repeat_fire = (hold_reg == period_last);
        default: repeat_fire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_reg <= IDLE;
      hold_reg  <= '0;
    end else if (!i_Button) begin
      state_reg <= IDLE;
      hold_reg  <= '0;
    end else if (press_edge) begin
      state_reg <= DELAY;
      hold_reg  <= '0;
    end else if (repeat_fire) begin
      state_reg <= REPEAT;
      hold_reg  <= '0;
    end else if (state_reg != IDLE) begin
      hold_reg  <= hold_reg + 24'd1;
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

  assign inc = cfg_ok & (press_edge | repeat_fire);

  // Segments decode the pre-edge count, so the display trails o_Count by one clock.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      prev_reg   <= 1'b1;
      count_reg  <= '0;
      wrap_reg   <= 1'b0;
      seg_hi_reg <= 7'b0000001;
      seg_lo_reg <= 7'b0000001;
    end else begin
      prev_reg   <= i_Button;
      wrap_reg   <= 1'b0;
      seg_hi_reg <= hex_seg(count_reg[7:4]);
      seg_lo_reg <= hex_seg(count_reg[3:0]);
      if (i_Clear) begin
        count_reg <= '0;
      end else if (inc) begin
        if (count_reg == c_MAX_COUNT) begin
          count_reg <= '0;
          wrap_reg  <= 1'b1;
        end else begin
          count_reg <= count_reg + 8'd1;
        end
      end
    end
  end

  assign o_Count  = count_reg;
  assign o_Wrap   = wrap_reg;
  assign o_Seg_Hi = seg_hi_reg;
  assign o_Seg_Lo = seg_lo_reg;

endmodule

// File: tb/tb_press_count_seg7.sv
// Bench for press_count_seg7: table-driven scoreboard on a 0x0F-max instance,
// hand-written reset, clear-priority and hold/repeat sequences on a second instance.
`timescale 1ns/1ps
module tb_press_count_seg7;

  logic       clk;
  logic       rst_a_n, btn_a, clr_a;
  logic       rst_b_n, btn_b, clr_b;
  logic [7:0] count_a, count_b;
  logic       wrap_a, wrap_b;
  logic [6:0] hi_a, lo_a, hi_b, lo_b;

  press_count_seg7 #(.c_MAX_COUNT(8'hFF), .c_REPEAT_DELAY(8), .c_REPEAT_PERIOD(4)) dut_a (
    .i_Clk(clk), .i_Rst_L(rst_a_n), .i_Button(btn_a), .i_Clear(clr_a),
    .o_Count(count_a), .o_Wrap(wrap_a), .o_Seg_Hi(hi_a), .o_Seg_Lo(lo_a)
  );

  press_count_seg7 #(.c_MAX_COUNT(8'h0F)) dut_b (
    .i_Clk(clk), .i_Rst_L(rst_b_n), .i_Button(btn_b), .i_Clear(clr_b),
    .o_Count(count_b), .o_Wrap(wrap_b), .o_Seg_Hi(hi_b), .o_Seg_Lo(lo_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       btn;
    logic       clr;
    logic [7:0] cnt;
    logic       wrap;
  } vec_t;

  typedef struct {
    logic [7:0] cnt;
    logic       wrap;
    logic [6:0] hi;
    logic [6:0] lo;
  } exp_t;

  vec_t       vecs [96];
  int         n_vec;
  exp_t       sb [$];
  logic [6:0] seg_tab [16];
  int         passed;
  int         total;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic add(input logic btn, input logic clr, input logic [7:0] cnt, input logic wrap);
    vecs[n_vec] = '{btn, clr, cnt, wrap};
    n_vec++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t       e;
    exp_t       got;
    logic [7:0] prev_cnt;
    int         exp_rep;

    passed = 0;
    total  = 0;
    n_vec  = 0;

    seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111; seg_tab[2]  = 7'b0010010;
    seg_tab[3]  = 7'b0000110; seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
    seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111; seg_tab[8]  = 7'b0000000;
    seg_tab[9]  = 7'b0000100; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
    seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010; seg_tab[14] = 7'b0110000;
    seg_tab[15] = 7'b0111000;

    // Button held across reset release: no count until a release and a fresh press.
    add(1, 0, 8'd0, 0);
    add(1, 0, 8'd0, 0);
    add(0, 0, 8'd0, 0);
    add(1, 0, 8'd1, 0);
    for (int k = 0; k < 9; k++) add(1, 0, 8'd1, 0);
    add(0, 0, 8'd1, 0);
    add(0, 0, 8'd1, 0);
    add(0, 1, 8'd0, 0);
    // Sixteen presses from zero: wrap pulse on the sixteenth only.
    for (int k = 1; k <= 16; k++) begin
      add(1, 0, 8'(k % 16), (k == 16));
      add(0, 0, 8'(k % 16), 0);
    end
    for (int k = 1; k <= 15; k++) begin
      add(1, 0, 8'(k), 0);
      add(0, 0, 8'(k), 0);
    end
    // Clear and press together at the max value: clear wins, no wrap.
    add(1, 1, 8'd0, 0);
    add(0, 0, 8'd0, 0);

    rst_a_n = 1'b0; btn_a = 1'b0; clr_a = 1'b0;
    rst_b_n = 1'b0; btn_b = 1'b1; clr_b = 1'b0;
    step();
    step();
    check("rst_count", count_b, 8'h00);
    check("rst_wrap",  {7'd0, wrap_b}, 8'h00);
    check("rst_hi",    {1'b0, hi_b}, 8'h01);
    check("rst_lo",    {1'b0, lo_b}, 8'h01);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    prev_cnt = 8'h00;
    for (int i = 0; i < n_vec; i++) begin
      btn_b  = vecs[i].btn;
      clr_b  = vecs[i].clr;
      e.cnt  = vecs[i].cnt;
      e.wrap = vecs[i].wrap;
      e.hi   = seg_tab[prev_cnt[7:4]];
      e.lo   = seg_tab[prev_cnt[3:0]];
      sb.push_back(e);
      prev_cnt = vecs[i].cnt;
      step();
      got = sb.pop_front();
      $display("vec %0d btn=%0b clr=%0b count=%0h wrap=%0b hi=%b lo=%b",
               i, vecs[i].btn, vecs[i].clr, count_b, wrap_b, hi_b, lo_b);
      check($sformatf("vec%0d_count", i), count_b, got.cnt);
      check($sformatf("vec%0d_wrap", i),  {7'd0, wrap_b}, {7'd0, got.wrap});
      check($sformatf("vec%0d_hi", i),    {1'b0, hi_b}, {1'b0, got.hi});
      check($sformatf("vec%0d_lo", i),    {1'b0, lo_b}, {1'b0, got.lo});
    end
    btn_b = 1'b0;
    clr_b = 1'b0;

    // Count to five, then assert reset between clock edges.
    for (int k = 1; k <= 5; k++) begin
      btn_a = 1'b1;
      step();
      check($sformatf("a_press%0d", k), count_a, 8'(k));
      btn_a = 1'b0;
      step();
    end
    $display("a count=%0h hi=%b lo=%b before async reset", count_a, hi_a, lo_a);
    check("a_pre_rst_lo", {1'b0, lo_a}, {1'b0, seg_tab[5]});
    rst_a_n = 1'b0;
    #1;
    check("a_async_count", count_a, 8'h00);
    check("a_async_wrap",  {7'd0, wrap_a}, 8'h00);
    check("a_async_hi",    {1'b0, hi_a}, 8'h01);
    check("a_async_lo",    {1'b0, lo_a}, 8'h01);
    #1;
    rst_a_n = 1'b1;
    step();

    // Reach 0x2A, then clear and press in the same cycle.
    for (int k = 0; k < 42; k++) begin
      btn_a = 1'b1;
      step();
      btn_a = 1'b0;
      step();
    end
    $display("a count=%0h hi=%b lo=%b after 42 presses", count_a, hi_a, lo_a);
    check("a_count_2a", count_a, 8'h2A);
    check("a_hi_2",     {1'b0, hi_a}, {1'b0, seg_tab[2]});
    check("a_lo_a",     {1'b0, lo_a}, {1'b0, seg_tab[10]});
    btn_a = 1'b1;
    clr_a = 1'b1;
    step();
    $display("a clear+press count=%0h wrap=%0b", count_a, wrap_a);
    check("a_clr_count", count_a, 8'h00);
    check("a_clr_wrap",  {7'd0, wrap_a}, 8'h00);
    btn_a = 1'b0;
    clr_a = 1'b0;
    step();
    check("a_clr_after_count", count_a, 8'h00);
    check("a_clr_after_wrap",  {7'd0, wrap_a}, 8'h00);

    // Long hold: repeats at +8, +12, +16, +20 only when auto-repeat is built in.
    btn_a = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      step();
`ifdef PRESS_AUTO_REPEAT_EN
      exp_rep = 1 + int'(k >= 8) + int'(k >= 12) + int'(k >= 16) + int'(k >= 20);
`else
      exp_rep = 1;
`endif
      $display("hold cycle %0d count=%0h", k, count_a);
      check($sformatf("hold%0d_count", k), count_a, 8'(exp_rep));
    end
    btn_a = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("hold_release_count", count_a, 8'(exp_rep));
    check("hold_release_wrap",  {7'd0, wrap_a}, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
